// File: rtl/fast_vram_pkg.sv
// Shared slot numbering, address-mux encodings and size defaults for the fast-VRAM scheduler.
// FAST_VRAM_CPU_DUAL_SLOT_EN: when defined, slot 7 is a second CPU write slot.
package fast_vram_pkg;

    localparam int PARSE_LAST_DEF = 381;
    localparam int ACTIVE_MAX_DEF = 96;

    typedef enum logic [2:0] {
        SLOT_CPU    = 3'd0,
        SLOT_PARSE  = 3'd1,
        SLOT_RENDER = 3'd2,
        SLOT_ACT_WR = 3'd3,
        SLOT_ACT_RD = 3'd4,
        SLOT_SHRINK = 3'd5,
        SLOT_IDLE   = 3'd6,
        SLOT_CPU2   = 3'd7
    } slot_e;

    typedef enum logic [1:0] {
        SEL_CPU    = 2'b00,
        SEL_PARSE  = 2'b01,
        SEL_ACT_WR = 2'b10,
        SEL_ACT_RD = 2'b11
    } addr_sel_e;

    function automatic logic is_cpu_slot(input slot_e s);
`ifdef FAST_VRAM_CPU_DUAL_SLOT_EN
        return (s == SLOT_CPU) || (s == SLOT_CPU2);
`else
        return s == SLOT_CPU;
`endif
    endfunction

endpackage

// File: rtl/fast_vram_cpu_port.sv
// CPU write-request latch: holds one request, grants it in a CPU slot, acknowledges it once.
module fast_vram_cpu_port
    import fast_vram_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_n,
    input  slot_e slot_nxt,
    output logic  grant_nxt,
    output logic  ack
);

    logic pending;
    logic grant_q;

    // A request arriving now can use the very next slot; the grant/ack window blocks re-grants.
    always_comb begin
        grant_nxt = (pending || !req_n) && !grant_q && !ack && is_cpu_slot(slot_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            grant_q <= 1'b0;
            ack     <= 1'b0;
        end else begin
            grant_q <= grant_nxt;
            ack     <= grant_q;
            if (ack) begin
                pending <= 1'b0;
            end else if (!req_n) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_vram_slot_sched.sv
// Eight-slot fast-VRAM access scheduler: CPU writes, sprite parse, active-list write/read, render.
// FAST_VRAM_CPU_DUAL_SLOT_EN (see fast_vram_pkg) adds slot 7 as a CPU slot.
module fast_vram_slot_sched
    import fast_vram_pkg::*;
#(
    parameter int PARSE_LAST = PARSE_LAST_DEF,
    parameter int ACTIVE_MAX = ACTIVE_MAX_DEF
) (
    input  logic       CLK_24M,
    input  logic       nRESET,
    input  logic       NEW_LINE,
    input  logic       nVRAM_WRITE_REQ,
    input  logic       MATCH,
    input  logic       RELOAD_RD,
    output logic [2:0] SLOT,
    output logic [1:0] ADDR_SEL,
    output logic       nCWE,
    output logic       CPU_ACK,
    output logic       LATCH_PARSE,
    output logic       LATCH_RENDER,
    output logic       LATCH_ACTIVE,
    output logic       LATCH_SHRINK,
    output logic [8:0] PARSE_INDEX,
    output logic [6:0] ACTIVE_WR_ADDR,
    output logic [6:0] ACTIVE_RD_ADDR,
    output logic       PARSING_DONE,
    output logic       ACTIVE_FULL
);

    localparam logic [8:0] PARSE_LAST_V = 9'(PARSE_LAST);
    localparam logic [6:0] ACTIVE_MAX_V = 7'(ACTIVE_MAX);

    slot_e      slot_q, slot_nxt;
    addr_sel_e  sel_q, sel_nxt;
    logic       ncwe_q, act_we_q, act_we_nxt, cpu_grant_nxt;
    logic       lp_q, lr_q, la_q, ls_q, lp_nxt, lr_nxt, la_nxt, ls_nxt;
    logic [8:0] pidx_q;
    logic [6:0] wr_q, rd_q, wr_inc;
    logic       done_q, full_q, done_d, full_d;

    fast_vram_cpu_port u_cpu (
        .clk      (CLK_24M),
        .rst_n    (nRESET),
        .req_n    (nVRAM_WRITE_REQ),
        .slot_nxt (slot_nxt),
        .grant_nxt(cpu_grant_nxt),
        .ack      (CPU_ACK)
    );

    // Outputs are decoded for the upcoming slot, so the line state seen is post-NEW_LINE.
    always_comb begin
        slot_nxt   = slot_e'(slot_q + 3'd1);
        done_d     = NEW_LINE ? 1'b0 : done_q;
        full_d     = NEW_LINE ? 1'b0 : full_q;
        wr_inc     = wr_q + 7'd1;
        sel_nxt    = SEL_CPU;
        act_we_nxt = 1'b0;
        lp_nxt     = 1'b0;
        lr_nxt     = 1'b0;
        la_nxt     = 1'b0;
        ls_nxt     = 1'b0;
        case (slot_nxt)
            SLOT_PARSE:  if (!done_d) sel_nxt = SEL_PARSE;
            SLOT_RENDER: begin
                sel_nxt = SEL_ACT_RD;
                lp_nxt  = (sel_q == SEL_PARSE);
            end
            SLOT_ACT_WR: begin
                lr_nxt = 1'b1;
                if (MATCH && !done_d && !full_d) begin
                    sel_nxt    = SEL_ACT_WR;
                    act_we_nxt = 1'b1;
                end
            end
            SLOT_ACT_RD: sel_nxt = SEL_ACT_RD;
            SLOT_SHRINK: begin
                sel_nxt = SEL_ACT_RD;
                la_nxt  = 1'b1;
            end
            SLOT_IDLE:   ls_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            slot_q   <= SLOT_CPU;
            sel_q    <= SEL_CPU;
            ncwe_q   <= 1'b1;
            act_we_q <= 1'b0;
            lp_q     <= 1'b0;
            lr_q     <= 1'b0;
            la_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            slot_q   <= slot_nxt;
            sel_q    <= sel_nxt;
            ncwe_q   <= !(act_we_nxt || cpu_grant_nxt);
            act_we_q <= act_we_nxt;
            lp_q     <= lp_nxt;
            lr_q     <= lr_nxt;
            la_q     <= la_nxt;
            ls_q     <= ls_nxt;
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            pidx_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            done_q <= 1'b1;
            full_q <= 1'b0;
        end else begin
            if (NEW_LINE) begin
                pidx_q <= '0;
                wr_q   <= '0;
                done_q <= 1'b0;
                full_q <= 1'b0;
            end else if (slot_q == SLOT_ACT_WR && !done_q) begin
                if (act_we_q) begin
                    wr_q <= wr_inc;
                    if (wr_inc == ACTIVE_MAX_V) full_q <= 1'b1;
                end
                if (pidx_q == PARSE_LAST_V) begin
                    done_q <= 1'b1;
                end else begin
                    pidx_q <= pidx_q + 9'd1;
                end
            end
            if (RELOAD_RD) begin
                rd_q <= '0;
            end else if (slot_q == SLOT_ACT_RD) begin
                rd_q <= rd_q + 7'd1;
            end
        end
    end

    assign SLOT           = slot_q;
    assign ADDR_SEL       = sel_q;
    assign nCWE           = ncwe_q;
    assign LATCH_PARSE    = lp_q;
    assign LATCH_RENDER   = lr_q;
    assign LATCH_ACTIVE   = la_q;
    assign LATCH_SHRINK   = ls_q;
    assign PARSE_INDEX    = pidx_q;
    assign ACTIVE_WR_ADDR = wr_q;
    assign ACTIVE_RD_ADDR = rd_q;
    assign PARSING_DONE   = done_q;
    assign ACTIVE_FULL    = full_q;

endmodule

// File: tb/tb_fast_vram_slot_sched.sv
// Self-checking bench for fast_vram_slot_sched: cycle-indexed reference model plus directed checks.
module tb_fast_vram_slot_sched;

`ifdef FAST_VRAM_CPU_DUAL_SLOT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam int PLAST = 381;
    localparam int AMAX  = 96;

    logic       CLK_24M = 1'b0;
    logic       nRESET = 1'b1;
    logic       NEW_LINE = 1'b0;
    logic       nVRAM_WRITE_REQ = 1'b1;
    logic       MATCH = 1'b0;
    logic       RELOAD_RD = 1'b0;
    logic [2:0] SLOT;
    logic [1:0] ADDR_SEL;
    logic       nCWE, CPU_ACK;
    logic       LATCH_PARSE, LATCH_RENDER, LATCH_ACTIVE, LATCH_SHRINK;
    logic [8:0] PARSE_INDEX;
    logic [6:0] ACTIVE_WR_ADDR, ACTIVE_RD_ADDR;
    logic       PARSING_DONE, ACTIVE_FULL;

    int errors = 0;
    int checks = 0;

    fast_vram_slot_sched #(.PARSE_LAST(PLAST), .ACTIVE_MAX(AMAX)) dut (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .NEW_LINE(NEW_LINE),
        .nVRAM_WRITE_REQ(nVRAM_WRITE_REQ), .MATCH(MATCH), .RELOAD_RD(RELOAD_RD),
        .SLOT(SLOT), .ADDR_SEL(ADDR_SEL), .nCWE(nCWE), .CPU_ACK(CPU_ACK),
        .LATCH_PARSE(LATCH_PARSE), .LATCH_RENDER(LATCH_RENDER),
        .LATCH_ACTIVE(LATCH_ACTIVE), .LATCH_SHRINK(LATCH_SHRINK),
        .PARSE_INDEX(PARSE_INDEX), .ACTIVE_WR_ADDR(ACTIVE_WR_ADDR),
        .ACTIVE_RD_ADDR(ACTIVE_RD_ADDR), .PARSING_DONE(PARSING_DONE),
        .ACTIVE_FULL(ACTIVE_FULL)
    );

    always #5 CLK_24M = ~CLK_24M;

    // Reference model: cycle k since reset release runs slot k%8; CPU grants are scheduled as cycle numbers.
    int k, m_pidx, m_wr, m_rd, grant_cyc, busy_end, ended, prev_sel;
    bit m_done, m_full, e_write;
    int e_slot, e_sel;
    bit e_ncwe, e_ack, e_lp, e_lr, e_la, e_ls;

    function automatic bit cpu_slot(input int s);
        return (s == 0) || (DUAL && s == 7);
    endfunction

    always @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            k = 0; m_pidx = 0; m_wr = 0; m_rd = 0; m_done = 1'b1; m_full = 1'b0;
            grant_cyc = -10; busy_end = -10; e_write = 1'b0; prev_sel = 0;
            e_slot = 0; e_sel = 0; e_ncwe = 1'b1; e_ack = 1'b0;
            e_lp = 1'b0; e_lr = 1'b0; e_la = 1'b0; e_ls = 1'b0;
        end else begin
            ended = k % 8;
            k++;
            if (NEW_LINE) begin
                m_pidx = 0; m_wr = 0; m_done = 1'b0; m_full = 1'b0;
            end else if (ended == 3 && !m_done) begin
                if (e_write) begin
                    m_wr++;
                    if (m_wr == AMAX) m_full = 1'b1;
                end
                if (m_pidx == PLAST) m_done = 1'b1;
                else m_pidx++;
            end
            if (RELOAD_RD) m_rd = 0;
            else if (ended == 4) m_rd = (m_rd + 1) % 128;
            if (!nVRAM_WRITE_REQ && k > busy_end) begin
                grant_cyc = k;
                while (!cpu_slot(grant_cyc % 8)) grant_cyc++;
                busy_end = grant_cyc + 2;
            end
            prev_sel = e_sel;
            e_slot = k % 8;
            e_sel = 0; e_ncwe = 1'b1; e_write = 1'b0;
            e_lp = 1'b0; e_lr = 1'b0; e_la = 1'b0; e_ls = 1'b0;
            case (e_slot)
                1: if (!m_done) e_sel = 1;
                2: begin e_sel = 3; e_lp = (prev_sel == 1); end
                3: begin
                    e_lr = 1'b1;
                    if (MATCH && !m_done && !m_full) begin
                        e_write = 1'b1; e_sel = 2; e_ncwe = 1'b0;
                    end
                end
                4: e_sel = 3;
                5: begin e_sel = 3; e_la = 1'b1; end
                6: e_ls = 1'b1;
                default: ;
            endcase
            if (k == grant_cyc) e_ncwe = 1'b0;
            e_ack = (k == grant_cyc + 1);
        end
    end

    always @(negedge CLK_24M) begin
        checks++;
        if (SLOT != e_slot[2:0] || ADDR_SEL != e_sel[1:0] || nCWE != e_ncwe || CPU_ACK != e_ack ||
            LATCH_PARSE != e_lp || LATCH_RENDER != e_lr || LATCH_ACTIVE != e_la ||
            LATCH_SHRINK != e_ls || PARSE_INDEX != m_pidx[8:0] || ACTIVE_WR_ADDR != m_wr[6:0] ||
            ACTIVE_RD_ADDR != m_rd[6:0] || PARSING_DONE != m_done || ACTIVE_FULL != m_full) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got slot=%0d sel=%0d ncwe=%0b ack=%0b lat=%b%b%b%b pidx=%0d wr=%0d rd=%0d done=%0b full=%0b | exp slot=%0d sel=%0d ncwe=%0b ack=%0b lat=%b%b%b%b pidx=%0d wr=%0d rd=%0d done=%0b full=%0b",
                     $time, SLOT, ADDR_SEL, nCWE, CPU_ACK, LATCH_PARSE, LATCH_RENDER, LATCH_ACTIVE,
                     LATCH_SHRINK, PARSE_INDEX, ACTIVE_WR_ADDR, ACTIVE_RD_ADDR, PARSING_DONE, ACTIVE_FULL,
                     e_slot, e_sel, e_ncwe, e_ack, e_lp, e_lr, e_la, e_ls, m_pidx, m_wr, m_rd, m_done, m_full);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK_24M);
        #2;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 16; i++) begin
            step();
            if (SLOT == s[2:0]) break;
        end
        chk("wait_slot", int'(SLOT), s);
    endtask

    task automatic start_line();
        wait_slot(7);
        NEW_LINE = 1'b1;
        step();
        NEW_LINE = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, n3, acks, lows;

        // Reset state and free-running slot sequence
        #1 nRESET = 1'b0;
        #1;
        chk("rst_slot", int'(SLOT), 0);
        chk("rst_ncwe", int'(nCWE), 1);
        chk("rst_sel", int'(ADDR_SEL), 0);
        chk("rst_done", int'(PARSING_DONE), 1);
        chk("rst_full", int'(ACTIVE_FULL), 0);
        @(posedge CLK_24M);
        @(posedge CLK_24M);
        #2 nRESET = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("slot_seq", int'(SLOT), i % 8);
            chk("idle_ncwe", int'(nCWE), 1);
            chk("idle_done", int'(PARSING_DONE), 1);
        end

        // Line with MATCH in every slot 3: writes at 0..95 then full
        MATCH = 1'b1;
        start_line();
        nwr = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (SLOT == 3'd3 && !nCWE) begin
                chk("wr_sel", int'(ADDR_SEL), 2);
                chk("wr_addr", int'(ACTIVE_WR_ADDR), nwr);
                nwr++;
            end
            if (PARSING_DONE) break;
        end
        chk("fill_done", int'(PARSING_DONE), 1);
        chk("fill_writes", nwr, 96);
        chk("fill_full", int'(ACTIVE_FULL), 1);
        chk("fill_wr_addr", int'(ACTIVE_WR_ADDR), 96);
        chk("fill_pidx", int'(PARSE_INDEX), 381);

        // Line with no matches: 382 parse steps, index holds at 381
        MATCH = 1'b0;
        start_line();
        n3 = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (SLOT == 3'd3 && !PARSING_DONE) n3++;
            if (PARSING_DONE) break;
        end
        chk("parse_slot3_count", n3, 382);
        chk("parse_pidx", int'(PARSE_INDEX), 381);
        chk("parse_wr_addr", int'(ACTIVE_WR_ADDR), 0);
        for (int i = 0; i < 8; i++) step();
        chk("parse_pidx_hold", int'(PARSE_INDEX), 381);
        chk("parse_done_hold", int'(PARSING_DONE), 1);

        // CPU request in slot 3
        wait_slot(3);
        nVRAM_WRITE_REQ = 1'b0;
        step();
        nVRAM_WRITE_REQ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (!nCWE) break;
        end
        chk("cpu3_ncwe", int'(nCWE), 0);
        chk("cpu3_slot", int'(SLOT), DUAL ? 7 : 0);
        chk("cpu3_sel", int'(ADDR_SEL), 0);
        step();
        chk("cpu3_ack", int'(CPU_ACK), 1);
        chk("cpu3_ncwe_after", int'(nCWE), 1);

        // CPU request during slot 0 goes to the following CPU slot
        wait_slot(0);
        nVRAM_WRITE_REQ = 1'b0;
        step();
        nVRAM_WRITE_REQ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (!nCWE) break;
        end
        chk("cpu0_slot", int'(SLOT), DUAL ? 7 : 0);
        step();
        chk("cpu0_ack", int'(CPU_ACK), 1);

        // CPU request during slot 7 is served in slot 0
        wait_slot(7);
        nVRAM_WRITE_REQ = 1'b0;
        step();
        nVRAM_WRITE_REQ = 1'b1;
        chk("cpu7_slot", int'(SLOT), 0);
        chk("cpu7_ncwe", int'(nCWE), 0);
        step();
        chk("cpu7_ack", int'(CPU_ACK), 1);

        // RELOAD_RD during slot 4 beats the increment
        wait_slot(4);
        RELOAD_RD = 1'b1;
        step();
        RELOAD_RD = 1'b0;
        chk("reload_rd", int'(ACTIVE_RD_ADDR), 0);
        wait_slot(5);
        chk("rd_after_reload", int'(ACTIVE_RD_ADDR), 1);

        // Reset during a slot-3 active write with a CPU write pending
        MATCH = 1'b1;
        start_line();
        wait_slot(2);
        nVRAM_WRITE_REQ = 1'b0;
        step();
        nVRAM_WRITE_REQ = 1'b1;
        chk("pre_rst_write", int'(nCWE), 0);
        #1 nRESET = 1'b0;
        #1;
        chk("rst_mid_ncwe", int'(nCWE), 1);
        chk("rst_mid_slot", int'(SLOT), 0);
        chk("rst_mid_ack", int'(CPU_ACK), 0);
        @(posedge CLK_24M);
        @(posedge CLK_24M);
        #2 nRESET = 1'b1;
        acks = 0;
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (CPU_ACK) acks++;
            if (!nCWE) lows++;
        end
        chk("rst_dropped_ack", acks, 0);
        chk("rst_no_writes", lows, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fast_vram_slot_sched.md
FAST_VRAM_SLOT_SCHED -- requirements
Module: fast_vram_slot_sched

Interface
REQ-001 SHALL have parameter PARSE_LAST, default 381, meaning the last sprite Y-attribute index parsed per line.
REQ-002 SHALL have parameter ACTIVE_MAX, default 96, meaning the active-list capacity in entries.
REQ-003 SHALL have port CLK_24M  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nRESET  in  1  asynchronous active-low reset.
REQ-005 SHALL have port NEW_LINE  in  1  one-cycle pulse that starts a new line.
REQ-006 SHALL have port nVRAM_WRITE_REQ  in  1  CPU fast-VRAM write request, active-low, level.
REQ-007 SHALL have port MATCH  in  1  Y-match result for the entry latched by LATCH_PARSE.
REQ-008 SHALL have port RELOAD_RD  in  1  pulse that clears the active-list read address.
REQ-009 SHALL have port SLOT  out  3  current slot number.
REQ-010 SHALL have port ADDR_SEL  out  2  address-mux select: 00 CPU, 01 parse, 10 active write, 11 active read/render.
REQ-011 SHALL have port nCWE  out  1  fast-VRAM write enable, active-low.
REQ-012 SHALL have port CPU_ACK  out  1  one-cycle pulse on completion of a CPU write.
REQ-013 SHALL have ports LATCH_PARSE, LATCH_RENDER, LATCH_ACTIVE, LATCH_SHRINK  out  1 each  data-capture strobes.
REQ-014 SHALL have ports PARSE_INDEX (9), ACTIVE_WR_ADDR (7) and ACTIVE_RD_ADDR (7), all outputs.
REQ-015 SHALL have ports PARSING_DONE and ACTIVE_FULL, both out, 1 bit each.

Function
REQ-016 SHALL step SLOT 0..7 once per clock and wrap from 7 to 0.
REQ-017 SHALL assign slots as follows: 0 CPU, 1 parse read, 2 render Y read, 3 active write, 4 active read, 5 shrink read, 6 idle, 7 CPU or idle (see REQ-031).
REQ-018 SHALL register all outputs so that they are valid during the cycle in which SLOT equals the slot they belong to.
REQ-019 SHALL latch a low nVRAM_WRITE_REQ as pending, serve it in the next CPU slot with ADDR_SEL=00 and nCWE=0 for 1 cycle, pulse CPU_ACK in the following cycle, then clear pending.
REQ-020 SHALL ignore further requests while a CPU write is pending; a request that arrives during a CPU slot SHALL be served in the next CPU slot.
REQ-021 SHALL select ADDR_SEL=01 in slot 1 only while PARSING_DONE=0 and pulse LATCH_PARSE in slot 2.
REQ-022 SHALL, in slot 3, when MATCH=1, PARSING_DONE=0 and ACTIVE_FULL=0, drive ADDR_SEL=10 and nCWE=0, then increment ACTIVE_WR_ADDR.
REQ-023 SHALL increment PARSE_INDEX at the end of every slot 3 while PARSING_DONE=0.
REQ-024 SHALL set PARSING_DONE after the slot 3 in which PARSE_INDEX equals PARSE_LAST; PARSE_INDEX SHALL then hold.
REQ-025 SHALL set ACTIVE_FULL when ACTIVE_WR_ADDR reaches ACTIVE_MAX; further writes SHALL be suppressed.
REQ-026 SHALL drive ADDR_SEL=11 in slots 2, 4 and 5, pulse LATCH_RENDER, LATCH_ACTIVE and LATCH_SHRINK respectively one cycle later, and increment ACTIVE_RD_ADDR after slot 4 (wrapping at 127).
REQ-027 SHALL, on NEW_LINE, clear PARSE_INDEX, ACTIVE_WR_ADDR, PARSING_DONE and ACTIVE_FULL; NEW_LINE SHALL take priority over a simultaneous increment.
REQ-028 SHALL, on RELOAD_RD, clear ACTIVE_RD_ADDR; RELOAD_RD SHALL take priority over a simultaneous increment.
REQ-029 SHALL keep nCWE=1 in every slot that is not granted a write.

Reset
REQ-030 SHALL, on nRESET=0, immediately force SLOT=0, all counters to 0, pending CPU write cleared, nCWE=1, all strobes and CPU_ACK 0, ADDR_SEL=00, PARSING_DONE=1 and ACTIVE_FULL=0; an in-flight write SHALL be dropped without CPU_ACK.

Configuration
REQ-031 SHALL serve CPU writes in both slot 0 and slot 7 when FAST_VRAM_CPU_DUAL_SLOT_EN is defined; without it, slot 7 SHALL be idle and CPU writes SHALL use slot 0 only.

Structure
REQ-032 SHALL place the slot-number constants, the ADDR_SEL encodings and the PARSE_LAST/ACTIVE_MAX defaults in a shared package fast_vram_pkg.
REQ-033 SHALL implement the CPU-request latch and acknowledge logic as one sub-module, fast_vram_cpu_port.

Verification
REQ-034 SHALL verify reset release: SLOT steps 0,1,...,7,0; nCWE stays 1; PARSING_DONE=1 until the first NEW_LINE.
REQ-035 SHALL verify that NEW_LINE followed by MATCH=1 in every slot 3 produces writes at ACTIVE_WR_ADDR 0..95, then ACTIVE_FULL=1 with no further nCWE=0 in slot 3.
REQ-036 SHALL verify that NEW_LINE with MATCH=0 sets PARSING_DONE after 382 slot-3 cycles, with PARSE_INDEX holding at 381.
REQ-037 SHALL verify that nVRAM_WRITE_REQ going low in slot 3 gives nCWE=0 with ADDR_SEL=00 in slot 0 without the macro, in slot 7 with it, and CPU_ACK one cycle later.
REQ-038 SHALL verify that RELOAD_RD coincident with slot 4 yields ACTIVE_RD_ADDR=0, not 1.
REQ-039 SHALL verify that nRESET asserted during a slot-3 write forces nCWE=1 immediately and produces no CPU_ACK.
